mc_sequencer: RTL

Multi-cycle control sequencer for the 54-instruction MIPS CPU. It sits beside the combinational instruction decoder. The decoder still produces datapath selects; this block decides *when* state-changing writes (IR, PC, RF, DM, HI/LO, EPC) happen. It adds ready/valid handshakes to instruction and data memory, a start/done handshake to the multiply/divide unit with a watchdog, trap sequencing, and a retired-instruction counter.

---
 rtl/mc_seq_pkg.sv | 27 ++
 rtl/md_watchdog.sv | 22 ++
 rtl/mc_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mc_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// decoder instruction classes and the default watchdog limit.
package mc_seq_pkg;
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MD_WAIT = 3'd5,
        S_TRAP    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_MULDIV = 3'd4;
    localparam logic [2:0] C_SYS    = 3'd5;

    localparam int MD_TIMEOUT_DEF = 64;

    function automatic logic is_illegal(input logic [2:0] cls);
        return cls >= 3'd6;
    endfunction
endpackage

// File: rtl/md_watchdog.sv
// Cycle counter guarding the mul/div handshake; expired flags the last
// permitted wait cycle so the sequencer can still honour a late md_done.
module md_watchdog #(
    parameter int MD_TIMEOUT = 64,
    localparam int MD_CNT_W  = $clog2(MD_TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [MD_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_count <= '0;
        else if (i_clear)  r_count <= '0;
        else if (i_enable) r_count <= r_count + 1'b1;
    end

    assign o_expired = (r_count == MD_CNT_W'(MD_TIMEOUT - 1));
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: decides when IR/PC/RF/DM/HILO/EPC
// writes happen, handshakes with memories and the mul/div unit.
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_inst_class,
    input  logic             i_exception_req,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    input  logic             i_md_done,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dm_we,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic             o_rf_we,
    output logic             o_hilo_we,
    output logic             o_epc_we,
    output logic             o_md_start,
    output logic [2:0]       o_state,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retired
);
    state_t           r_state, w_next;
    logic             r_fault;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire, w_md_clear, w_md_expired;

    assign w_md_clear = (r_state == S_EXEC) && (i_inst_class == C_MULDIV);

    md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_wdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_md_clear),
        .i_enable  (r_state == S_MD_WAIT),
        .o_expired (w_md_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_FAULT) r_fault <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (i_imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = (i_exception_req || is_illegal(i_inst_class)) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (i_inst_class)
                    C_ALU:           w_next = S_WB;
                    C_LOAD, C_STORE: w_next = S_MEM;
                    C_BRANCH:        w_next = S_FETCH;
                    C_MULDIV:        w_next = S_MD_WAIT;
                    C_SYS:           w_next = i_exception_req ? S_TRAP : S_WB;
                    default:         w_next = S_TRAP;
                endcase
            end
            S_MEM: if (i_dmem_ready) w_next = (i_inst_class == C_STORE) ? S_FETCH : S_WB;
            S_WB:  w_next = S_FETCH;
            // md_done takes priority over a simultaneous watchdog expiry
            S_MD_WAIT: begin
                if (i_md_done)         w_next = S_FETCH;
                else if (w_md_expired) w_next = S_FAULT;
            end
            S_TRAP:  w_next = S_FETCH;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dm_we    = 1'b0;
        o_ir_we    = 1'b0;
        o_pc_we    = 1'b0;
        o_rf_we    = 1'b0;
        o_hilo_we  = 1'b0;
        o_epc_we   = 1'b0;
        o_md_start = 1'b0;
        o_fault    = 1'b0;
        o_state    = 3'd0;
        o_retired  = '0;
        w_retire   = 1'b0;
        if (i_rst_n) begin
            o_state   = r_state;
            o_fault   = r_fault;
            o_retired = r_retired;
            case (r_state)
                S_FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_we    = i_imem_ready;
                end
                S_EXEC: begin
                    if (i_inst_class == C_BRANCH) begin
                        o_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                    o_md_start = (i_inst_class == C_MULDIV);
                end
                S_MEM: begin
                    o_dmem_req = 1'b1;
                    o_dm_we    = (i_inst_class == C_STORE);
                    if (i_dmem_ready && i_inst_class == C_STORE) begin
                        o_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                end
                S_WB: begin
                    o_rf_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    w_retire = 1'b1;
                end
                S_MD_WAIT: begin
                    o_hilo_we = i_md_done;
                    o_pc_we   = i_md_done;
                    w_retire  = i_md_done;
                end
                S_TRAP: begin
                    o_epc_we = 1'b1;
                    o_pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 1'b1;
    end
endmodule
